// File: rtl/mips_cpu_pc_seq.sv
// rtl/mips_cpu_pc_seq.sv - program-counter sequencer with branch delay slot and halt detection
//
// Purpose: computes the next PC for sequential, branch, jump and jump-register
// flow, executes exactly one delay-slot instruction after every taken transfer,
// and stops the core when a transfer targets HALT_ADDR.
//
// Ports:
//   clk, reset (async, active-low), clk_enable (low = hold everything)
//   pc_ctrl[1:0]  flow select: 00 SEQ, 01 BRANCH, 10 JUMP, 11 JR
//   branch_taken  branch condition, only looked at for BRANCH
//   imm16, jidx   instruction immediate fields
//   rs_data       register value used as the JR target
//   pc            current PC (instruction address)
//   pc_plus8      link value, combinational pc+8
//   in_delay_slot pc points at a delay-slot instruction
//   active        core is running
//   addr_err      misaligned transfer target seen (sticky)
//
// Optional feature macro: MIPS_PC_ALIGN_CHECK_EN
//   defined   : misaligned targets halt the core and set addr_err
//   undefined : target bits [1:0] are cleared, addr_err is tied 0

module mips_cpu_pc_seq #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(32'h00000000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [1:0]        pc_ctrl,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jidx,
  input  logic [ADDR_W-1:0] rs_data,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              in_delay_slot,
  output logic              active,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_SLOT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] tgt_q, tgt_q_nx, pc_nx;
  logic [ADDR_W-1:0] pc_inc, br_off, jmp_tgt, tgt_raw, tgt;
  logic              xfer;

  assign pc_inc   = pc + ADDR_W'(4);
  assign pc_plus8 = pc + ADDR_W'(8);
  assign br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // The jump region bits only exist when the PC is wider than 28 bits.
  generate
    if (ADDR_W > 28) begin : g_jmp_wide
      assign jmp_tgt = {pc_inc[ADDR_W-1:28], jidx, 2'b00};
    end else begin : g_jmp_narrow
      assign jmp_tgt = {jidx, 2'b00};
    end
  endgenerate

  always_comb begin
    tgt_raw = rs_data;
    case (pc_ctrl)
      2'b01:   tgt_raw = pc_inc + br_off;
      2'b10:   tgt_raw = jmp_tgt;
      default: tgt_raw = rs_data;
    endcase
  end

  // A not-taken branch behaves exactly like a sequential step.
  assign xfer = (pc_ctrl != 2'b00) && ((pc_ctrl != 2'b01) || branch_taken);

`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic misaligned, err_q, err_nx;
  assign tgt        = tgt_raw;
  assign misaligned = (tgt_raw[1:0] != 2'b00);
  assign addr_err   = err_q;
`else
  assign tgt      = tgt_raw & ~ADDR_W'(3);
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    tgt_q_nx = tgt_q;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    err_nx   = err_q;
`endif
    case (state)
      S_RUN: begin
        pc_nx = pc_inc;
        if (xfer) begin
`ifdef MIPS_PC_ALIGN_CHECK_EN
          if (misaligned) begin
            err_nx   = 1'b1;
            state_nx = S_HALT;
          end else begin
            tgt_q_nx = tgt;
            state_nx = S_SLOT;
          end
`else
          tgt_q_nx = tgt;
          state_nx = S_SLOT;
`endif
        end
      end
      // pc_ctrl is ignored here: a transfer sitting in a delay slot is dropped.
      S_SLOT: begin
        pc_nx    = tgt_q;
        state_nx = (tgt_q == HALT_ADDR) ? S_HALT : S_RUN;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_RUN;
      pc            <= RESET_VECTOR;
      tgt_q         <= '0;
      in_delay_slot <= 1'b0;
      active        <= 1'b1;
    end else if (clk_enable) begin
      state         <= state_nx;
      pc            <= pc_nx;
      tgt_q         <= tgt_q_nx;
      in_delay_slot <= (state_nx == S_SLOT);
      active        <= (state_nx != S_HALT);
    end
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (clk_enable) begin
      err_q <= err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// tb/tb_mips_cpu_pc_seq.sv - scoreboard bench for mips_cpu_pc_seq
module tb_mips_cpu_pc_seq;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic [1:0]  pc_ctrl = 2'b00;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] jidx = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc, pc_plus8;
  logic        in_delay_slot, active, addr_err;

  mips_cpu_pc_seq dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .pc_ctrl(pc_ctrl),
    .branch_taken(branch_taken), .imm16(imm16), .jidx(jidx), .rs_data(rs_data),
    .pc(pc), .pc_plus8(pc_plus8), .in_delay_slot(in_delay_slot),
    .active(active), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        slot;
    logic        act;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Architectural reference: current pc, an optional pending target, halted flag.
  logic [31:0] m_pc, m_tgt;
  bit          m_pend, m_halt, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_outputs(input exp_t e);
    chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".pc_plus8"}, pc_plus8, e.pc + 32'd8);
    chk({e.tag, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, e.slot});
    chk({e.tag, ".active"}, {31'd0, active}, {31'd0, e.act});
    chk({e.tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
  endtask

  function automatic exp_t model_now(input string tag);
    exp_t e;
    e.pc = m_pc; e.slot = m_pend; e.act = !m_halt; e.err = m_err; e.tag = tag;
    return e;
  endfunction

  // Monitor: pops one expectation per clock at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk_outputs(exp_q.pop_front());
  end

  task automatic model_step(input logic [1:0] ctrl, input logic tk, input logic [15:0] imm,
                            input logic [25:0] ji, input logic [31:0] rs);
    logic [31:0] t;
    if (m_halt) return;
    if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 0;
      if (m_tgt == HA) m_halt = 1;
      return;
    end
    if (ctrl == 2'b00 || (ctrl == 2'b01 && !tk)) begin
      m_pc = m_pc + 32'd4;
      return;
    end
    case (ctrl)
      2'b01:   t = m_pc + 32'd4 + 32'(int'($signed(imm)) * 4);
      2'b10:   t = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(ji) * 4);
      default: t = rs;
    endcase
    m_pc = m_pc + 32'd4;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    if (t % 4 != 0) begin
      m_err  = 1;
      m_halt = 1;
      return;
    end
`else
    t = t - (t % 4);
`endif
    m_tgt  = t;
    m_pend = 1;
  endtask

  task automatic step(input logic [1:0] ctrl, input logic tk, input logic [15:0] imm,
                      input logic [25:0] ji, input logic [31:0] rs, input logic en,
                      input string tag);
    pc_ctrl = ctrl; branch_taken = tk; imm16 = imm; jidx = ji; rs_data = rs; clk_enable = en;
    if (en) model_step(ctrl, tk, imm, ji, rs);
    @(posedge clk);
    exp_q.push_back(model_now(tag));
    @(negedge clk);
    #1;
  endtask

  // Asserted mid-cycle, away from any clock edge, so the check proves asynchrony.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    m_pc = RV; m_tgt = '0; m_pend = 0; m_halt = 0; m_err = 0;
    #1;
    chk_outputs(model_now(tag));
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic rand_step(input string tag);
    logic [31:0] rs;
    rs = ($urandom_range(0, 7) == 0) ? HA : $urandom;
    step(2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 26'($urandom), rs,
         ($urandom_range(0, 3) != 0), tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #1;
    do_reset("t1_reset");
    for (int i = 0; i < 3; i++) step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t1_seq");

    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t2_seq");
    step(2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 1, "t2_branch");
    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t2_target");

    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t3_seq");
    step(2'b01, 0, 16'hFFFE, 26'h0, 32'h0, 1, "t3_not_taken");
    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t3_after");

    step(2'b11, 0, 16'h0, 26'h0, 32'h0, 1, "t4_jr0");
    step(2'b10, 0, 16'h0, 26'h1234, 32'h0, 1, "t4_halt");
    for (int i = 0; i < 5; i++) rand_step("t4_frozen");

    do_reset("t5_reset");
    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t5_seq");
    step(2'b10, 0, 16'h0, 26'h00ABCDE, 32'h0, 1, "t5_jump");
    for (int i = 0; i < 3; i++) step(2'b11, 1, 16'h0, 26'h0, 32'h0, 0, "t5_hold");
    do_reset("t5_async_reset");

    step(2'b11, 0, 16'h0, 26'h0, 32'h00001002, 1, "t6_jr_mis");
    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t6_after");
    step(2'b00, 0, 16'h0, 26'h0, 32'h0, 1, "t6_after2");

    for (int r = 0; r < 6; r++) begin
      do_reset("rand_reset");
      for (int i = 0; i < 40; i++) rand_step("rand");
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
